fetch_control_unit: RTL and testbench



---
 rtl/fetch_control_unit.sv | 133 +++++++++++++
 tb/tb_fetch_control_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control_unit.sv
// Fetch-stage controller: owns the program counter and drives the IR1
// load/flush strobes. Handles hazard stalls, taken-branch redirects with a
// configurable squash window, and a STOP halt released by resume or branch.
module fetch_control_unit #(
    parameter int                      PC_WIDTH     = 8,
    parameter int                      OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0] STOP_OPCODE  = 1,
    parameter logic [PC_WIDTH-1:0]     RESET_PC     = 0,
    parameter int                      FLUSH_CYCLES = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_stall,
    input  logic                    i_branch,
    input  logic [PC_WIDTH-1:0]     i_branch_target,
    input  logic [OPCODE_WIDTH-1:0] i_instr_opcode,
    input  logic                    i_resume,
    output logic [PC_WIDTH-1:0]     o_pc,
    output logic                    o_pc_write,
    output logic                    o_pc_sel,
    output logic                    o_ir1_load,
    output logic                    o_ir1_flush,
    output logic                    o_halted
);

    // Squash counter only needs to hold FLUSH_CYCLES-1, but keep at least one bit.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    w_flush_cnt_next;
    logic                r_halted;

    // Sequential PC advance wraps naturally at 2^PC_WIDTH.
    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    // Next-state, next-PC and strobe decode; branch outranks resume, stall and STOP.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_flush_cnt_next = r_flush_cnt;
        o_pc_write       = 1'b0;
        o_pc_sel         = 1'b0;
        o_ir1_load       = 1'b0;
        o_ir1_flush      = 1'b0;
        if (i_reset) begin
            // Strobes stay low while reset is held; registers are cleared asynchronously.
        end else if (i_branch) begin
            // Older taken branch wins everywhere, including out of HALT (STOP was wrong-path).
            o_pc_write  = 1'b1;
            o_pc_sel    = 1'b1;
            o_ir1_load  = 1'b1;
            o_ir1_flush = 1'b1;
            w_pc_next   = i_branch_target;
            if (FLUSH_CYCLES > 1) begin
                w_state_next     = ST_FLUSH;
                w_flush_cnt_next = CNT_LOAD;
            end else begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = '0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_stall) begin
                        // Hold everything while the hazard unit stalls.
                    end else if (i_instr_opcode == STOP_OPCODE) begin
                        // Park on the STOP address; resume steps past it.
                        w_state_next = ST_HALT;
                    end else begin
                        o_pc_write = 1'b1;
                        o_ir1_load = 1'b1;
                        w_pc_next  = w_pc_inc;
                    end
                end
                ST_FLUSH: begin
                    if (!i_stall) begin
                        // Wrong-path words are squashed, so STOP is not decoded here.
                        o_pc_write       = 1'b1;
                        o_ir1_load       = 1'b1;
                        o_ir1_flush      = 1'b1;
                        w_pc_next        = w_pc_inc;
                        w_flush_cnt_next = r_flush_cnt - CNT_W'(1);
                        if (r_flush_cnt <= CNT_W'(1)) begin
                            w_state_next = ST_RUN;
                        end
                    end
                end
                ST_HALT: begin
                    if (i_resume) begin
                        // Step past the STOP word without loading IR1.
                        o_pc_write   = 1'b1;
                        w_pc_next    = w_pc_inc;
                        w_state_next = ST_RUN;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // State, PC, squash counter and halted flag registers with asynchronous reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_flush_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_halted    <= (w_state_next == ST_HALT);
        end
    end

    assign o_pc     = r_pc;
    assign o_halted = r_halted;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Scoreboard bench for fetch_control_unit (PC_WIDTH=8, FLUSH_CYCLES=3).
module tb_fetch_control_unit;

    localparam int         FC   = 3;
    localparam logic [3:0] STOP = 4'd1;
    localparam logic [7:0] RPC  = 8'd0;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       branch;
    logic [7:0] target;
    logic [3:0] opcode;
    logic       resume;
    logic [7:0] pc;
    logic       pc_write;
    logic       pc_sel;
    logic       ir1_load;
    logic       ir1_flush;
    logic       halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       pw;
        logic       ps;
        logic       il;
        logic       fl;
        logic [7:0] pc;
        logic       halted;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: 0=RUN, 1=FLUSH, 2=HALT
    int         m_st;
    int         m_cnt;
    logic [7:0] m_pc;

    fetch_control_unit #(
        .PC_WIDTH    (8),
        .OPCODE_WIDTH(4),
        .STOP_OPCODE (STOP),
        .RESET_PC    (RPC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_stall        (stall),
        .i_branch       (branch),
        .i_branch_target(target),
        .i_instr_opcode (opcode),
        .i_resume       (resume),
        .o_pc           (pc),
        .o_pc_write     (pc_write),
        .o_pc_sel       (pc_sel),
        .o_ir1_load     (ir1_load),
        .o_ir1_flush    (ir1_flush),
        .o_halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_cnt = 0;
        m_pc  = RPC;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [7:0] tgt,
                              input logic [3:0] op, input logic rs, output exp_t e);
        logic [7:0] inc;
        inc = m_pc + 8'd1;
        e = '0;
        if (br) begin
            e.pw = 1'b1; e.ps = 1'b1; e.il = 1'b1; e.fl = 1'b1;
            m_pc  = tgt;
            m_st  = (FC > 1) ? 1 : 0;
            m_cnt = FC - 1;
        end else if (m_st == 0) begin
            if (!st) begin
                if (op == STOP) m_st = 2;
                else begin e.pw = 1'b1; e.il = 1'b1; m_pc = inc; end
            end
        end else if (m_st == 1) begin
            if (!st) begin
                e.pw = 1'b1; e.il = 1'b1; e.fl = 1'b1;
                m_pc = inc;
                m_cnt--;
                if (m_cnt == 0) m_st = 0;
            end
        end else begin
            if (rs) begin e.pw = 1'b1; m_pc = inc; m_st = 0; end
        end
        e.pc     = m_pc;
        e.halted = (m_st == 2);
    endtask

    // One clock cycle: entered just after a rising edge, leaves just after the next.
    task automatic step(input logic st, input logic br, input logic [7:0] tgt,
                        input logic [3:0] op, input logic rs);
        exp_t e;
        exp_t g;
        logic [7:0] pc_before;
        pc_before = pc;
        model_step(st, br, tgt, op, rs, e);
        sb_q.push_back(e);
        stall = st; branch = br; target = tgt; opcode = op; resume = rs;
        @(negedge clk);
        g = sb_q.pop_front();
        chk("pc_write", pc_write, g.pw);
        chk("pc_sel", pc_sel, g.ps);
        chk("ir1_load", ir1_load, g.il);
        chk("ir1_flush", ir1_flush, g.fl);
        @(posedge clk);
        #1;
        chk("pc", pc, g.pc);
        chk("halted", halted, g.halted);
        $display("cyc pc=%0d st=%b br=%b tgt=%0d op=%0d rs=%b -> pw=%b ps=%b il=%b fl=%b pc'=%0d halted=%b",
                 pc_before, st, br, tgt, op, rs, pc_write, pc_sel, ir1_load, ir1_flush, pc, halted);
    endtask

    task automatic run_to(input logic [7:0] dest);
        int n;
        n = 0;
        while (pc != dest && n < 300) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk("run_to", pc, dest);
    endtask

    // Safety net so the bench never hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 0; branch = 0; target = 0; opcode = 0; resume = 0;
        model_reset();
        #2;
        chk("rst_pc", pc, RPC);
        chk("rst_halted", halted, 0);
        chk("rst_strobes", {pc_write, pc_sel, ir1_load, ir1_flush}, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Free run from reset: 0,1,2,3,...
        step(0, 0, 0, 0, 0); chk("free_pc1", pc, 1);
        step(0, 0, 0, 0, 0); chk("free_pc2", pc, 2);
        step(0, 0, 0, 0, 0); chk("free_pc3", pc, 3);
        run_to(5);

        // Stall 3 cycles at pc=5
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("stall_hold", pc, 5);
        step(0, 0, 0, 0, 0); chk("stall_release", pc, 6);

        // Branch at pc=10 to 40, resume outside HALT is ignored on the way
        step(0, 0, 0, 0, 1);
        run_to(10);
        step(0, 1, 40, 0, 0); chk("br_target", pc, 40);
        step(0, 0, 0, 0, 0); chk("br_flush1", pc, 41);
        step(0, 0, 0, 0, 0); chk("br_flush2", pc, 42);
        step(0, 0, 0, 0, 0); chk("br_run", pc, 43);

        // Branch together with stall, plus a stall inside the squash window
        step(1, 1, 40, 0, 0); chk("brst_target", pc, 40);
        step(1, 0, 0, 0, 0); chk("flush_stall", pc, 40);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("brst_run", pc, 43);

        // Reach pc=7 via branch to 5; STOP in FLUSH is ignored, STOP at 7 halts
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, STOP, 0); chk("stop_in_flush", halted, 0);
        step(0, 0, 0, 0, 0);
        chk("at7", pc, 7);
        step(0, 0, 0, STOP, 0); chk("halt_pc", pc, 7); chk("halt_flag", halted, 1);
        step(1, 0, 0, STOP, 0);
        step(0, 0, 0, STOP, 0);
        step(1, 0, 0, STOP, 0); chk("halt_stall_pc", pc, 7);
        step(0, 0, 0, STOP, 1); chk("resume_pc", pc, 8); chk("resume_halted", halted, 0);

        // Halt again at 7, then branch+resume together
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, STOP, 0); chk("halt2", halted, 1);
        step(0, 1, 20, STOP, 1); chk("halt_br_pc", pc, 20); chk("halt_br_halted", halted, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("halt_br_run", pc, 23);

        // Wrap in FLUSH and in RUN
        step(0, 1, 254, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("wrap_flush", pc, 0);
        step(0, 1, 252, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); chk("wrap_pre", pc, 255);
        step(0, 0, 0, 0, 0); chk("wrap_run", pc, 0);

        // Asynchronous reset in the middle of FLUSH
        step(0, 1, 100, 0, 0);
        step(0, 0, 0, 0, 0);
        stall = 0; branch = 0; opcode = 0; resume = 0;
        #2;
        chk("pre_areset_flush", ir1_flush, 1);
        rst = 1'b1;
        #1;
        chk("areset_pc", pc, RPC);
        chk("areset_halted", halted, 0);
        chk("areset_strobes", {pc_write, pc_sel, ir1_load, ir1_flush}, 4'b0000);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(0, 0, 0, 0, 0); chk("post_reset_run", pc, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
